// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RISC-V fetch stage with prefetch FIFO and redirect flush
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    output logic        IF_mem_req_valid,
    input  logic        IF_mem_req_ready,
    output logic [31:0] IF_mem_req_addr,
    input  logic        IF_mem_resp_valid,
    input  logic [31:0] IF_mem_resp_data,
    output logic        IF_instr_valid,
    input  logic        IF_instr_ready,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_instr_pc,
    input  logic        IF_redirect_valid,
    input  logic [31:0] IF_redirect_pc,
    output logic        IF_misaligned
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_FETCH, ST_FLUSH} state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop;
    logic [CNT_W:0]   in_use;
    logic             misaligned;
    logic             accept;
    logic             pop;
    logic             push;
    logic [31:0]      redirect_aligned;

    assign accept           = IF_mem_req_valid & IF_mem_req_ready;
    assign pop              = IF_instr_valid & IF_instr_ready;
    // A response is kept only when nothing stale is pending and no redirect is flushing the FIFO.
    assign push             = IF_mem_resp_valid & (drop == '0) & ~IF_redirect_valid;
    assign outstanding_next = outstanding + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, IF_mem_resp_valid};
    // FIFO slots already used plus slots reserved by in-flight reads bound new requests.
    assign in_use           = {1'b0, fifo_count} + {1'b0, outstanding};
    assign redirect_aligned = {IF_redirect_pc[31:2], 2'b00};

    assign IF_mem_req_addr  = fetch_pc;
    assign IF_instr_valid   = (fifo_count != '0);
    assign IF_instr         = IF_instr_valid ? fifo_data[rd_ptr] : 32'h0;
    assign IF_instr_pc      = IF_instr_valid ? fifo_pc[rd_ptr] : 32'h0;
    assign IF_misaligned    = misaligned;

    // Next-state and request issue: FLUSH waits out stale responses before fetching again.
    always_comb begin
        state_next       = state;
        IF_mem_req_valid = 1'b0;
        case (state)
            ST_FETCH: begin
                if (!SYS_reset && !IF_redirect_valid && (in_use < DEPTH_V)) begin
                    IF_mem_req_valid = 1'b1;
                end
                if (IF_redirect_valid && (outstanding_next != '0)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((drop == '0) && !IF_redirect_valid) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // Control state: FSM, fetch/response PCs, in-flight and stale-response counters, sticky flag.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (IF_redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                drop     <= outstanding_next;
                if (IF_redirect_pc[1:0] != 2'b00) begin
                    misaligned <= 1'b1;
                end
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (IF_mem_resp_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset || IF_redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // FIFO storage; contents are only visible through valid entries so they need no reset.
    always_ff @(posedge SYS_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= IF_mem_resp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        IF_mem_req_valid;
    logic        IF_mem_req_ready;
    logic [31:0] IF_mem_req_addr;
    logic        IF_mem_resp_valid = 1'b0;
    logic [31:0] IF_mem_resp_data  = 32'h0;
    logic        IF_instr_valid;
    logic        IF_instr_ready;
    logic [31:0] IF_instr;
    logic [31:0] IF_instr_pc;
    logic        IF_redirect_valid;
    logic [31:0] IF_redirect_pc;
    logic        IF_misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .SYS_clk           (SYS_clk),
        .SYS_reset         (SYS_reset),
        .IF_mem_req_valid  (IF_mem_req_valid),
        .IF_mem_req_ready  (IF_mem_req_ready),
        .IF_mem_req_addr   (IF_mem_req_addr),
        .IF_mem_resp_valid (IF_mem_resp_valid),
        .IF_mem_resp_data  (IF_mem_resp_data),
        .IF_instr_valid    (IF_instr_valid),
        .IF_instr_ready    (IF_instr_ready),
        .IF_instr          (IF_instr),
        .IF_instr_pc       (IF_instr_pc),
        .IF_redirect_valid (IF_redirect_valid),
        .IF_redirect_pc    (IF_redirect_pc),
        .IF_misaligned     (IF_misaligned)
    );

    always #5 SYS_clk = ~SYS_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    // Memory model: fixed latency, in-order responses.
    int          mem_lat = 1;
    int          mcyc    = 0;
    int          n_accept = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    always @(negedge SYS_clk) begin
        if (SYS_reset) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (IF_mem_req_valid && IF_mem_req_ready) begin
            pend_addr.push_back(IF_mem_req_addr);
            pend_due.push_back(mcyc + mem_lat);
            n_accept++;
        end
    end

    always @(posedge SYS_clk) begin
        #1;
        mcyc++;
        IF_mem_resp_valid = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] == mcyc) begin
            IF_mem_resp_valid = 1'b1;
            IF_mem_resp_data  = word_at(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge SYS_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, IF_mem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, IF_mem_req_addr, 32'h0000_0000);
        check({tag, "_instr_valid"}, {31'b0, IF_instr_valid}, 32'd0);
        check({tag, "_instr"}, IF_instr, 32'd0);
        check({tag, "_instr_pc"}, IF_instr_pc, 32'd0);
        check({tag, "_misaligned"}, {31'b0, IF_misaligned}, 32'd0);
    endtask

    // Holds reset for two edges, checks outputs after the first, returns at start of cycle 0.
    task automatic do_reset(input string tag);
        SYS_reset         = 1'b1;
        IF_redirect_valid = 1'b0;
        next_cycle();
        at_neg();
        check_reset_outputs(tag);
        next_cycle();
        SYS_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        SYS_reset         = 1'b1;
        IF_mem_req_ready  = 1'b1;
        IF_instr_ready    = 1'b1;
        IF_redirect_valid = 1'b0;
        IF_redirect_pc    = 32'h0;

        // 1: streaming with 1-cycle memory, then request held while memory stalls
        mem_lat = 1;
        do_reset("t1_rst");
        for (int k = 0; k < 6; k++) begin
            at_neg();
            check("t1_req_valid", {31'b0, IF_mem_req_valid}, 32'd1);
            check("t1_req_addr", IF_mem_req_addr, 32'(4 * k));
            if (k >= 2) begin
                check("t1_instr_valid", {31'b0, IF_instr_valid}, 32'd1);
                check("t1_instr_pc", IF_instr_pc, 32'(4 * (k - 2)));
                check("t1_instr", IF_instr, word_at(32'(4 * (k - 2))));
            end
            next_cycle();
        end
        IF_mem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) IF_mem_req_ready = 1'b1;
            at_neg();
            check("t1_hold_valid", {31'b0, IF_mem_req_valid}, 32'd1);
            check("t1_hold_addr", IF_mem_req_addr, 32'd24);
            next_cycle();
        end

        // 2: consumer stalled -> exactly FIFO_DEPTH requests, then in-order drain
        IF_instr_ready = 1'b0;
        do_reset("t2_rst");
        acc0 = n_accept;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                at_neg();
                check("t2_req_stop", {31'b0, IF_mem_req_valid}, 32'd0);
                check("t2_hold_valid", {31'b0, IF_instr_valid}, 32'd1);
                check("t2_hold_instr", IF_instr, word_at(32'h0));
                check("t2_hold_pc", IF_instr_pc, 32'h0);
            end
            next_cycle();
        end
        check("t2_accepts", 32'(n_accept - acc0), 32'd4);
        IF_instr_ready = 1'b1;
        for (int k = 8; k < 13; k++) begin
            at_neg();
            check("t2_drain_valid", {31'b0, IF_instr_valid}, 32'd1);
            check("t2_drain_pc", IF_instr_pc, 32'(4 * (k - 8)));
            if (k == 8) check("t2_full_noreq", {31'b0, IF_mem_req_valid}, 32'd0);
            if (k == 9) begin
                check("t2_resume_valid", {31'b0, IF_mem_req_valid}, 32'd1);
                check("t2_resume_addr", IF_mem_req_addr, 32'd16);
            end
            next_cycle();
        end

        // 3: 3-cycle memory, redirect with two reads in flight
        mem_lat = 3;
        do_reset("t3_rst");
        for (int k = 0; k < 11; k++) begin
            IF_redirect_valid = (k == 2);
            IF_redirect_pc    = 32'h0000_0100;
            at_neg();
            if (k < 2) check("t3_req_addr", IF_mem_req_addr, 32'(4 * k));
            if (k >= 2 && k <= 5) check("t3_no_req", {31'b0, IF_mem_req_valid}, 32'd0);
            if (k == 6) begin
                check("t3_new_req_valid", {31'b0, IF_mem_req_valid}, 32'd1);
                check("t3_new_req_addr", IF_mem_req_addr, 32'h100);
            end
            if (k < 10) check("t3_no_instr", {31'b0, IF_instr_valid}, 32'd0);
            if (k == 10) begin
                check("t3_instr_valid", {31'b0, IF_instr_valid}, 32'd1);
                check("t3_instr_pc", IF_instr_pc, 32'h100);
                check("t3_instr", IF_instr, word_at(32'h100));
            end
            next_cycle();
        end
        IF_redirect_valid = 1'b0;

        // 4: redirect coinciding with a response and a completing handshake
        mem_lat = 2;
        do_reset("t4_rst");
        for (int k = 0; k < 10; k++) begin
            IF_redirect_valid = (k == 3);
            IF_redirect_pc    = 32'h0000_0040;
            at_neg();
            if (k == 2) check("t4_req_addr", IF_mem_req_addr, 32'd8);
            if (k == 3) begin
                check("t4_hs_valid", {31'b0, IF_instr_valid}, 32'd1);
                check("t4_hs_pc", IF_instr_pc, 32'h0);
                check("t4_redir_noreq", {31'b0, IF_mem_req_valid}, 32'd0);
            end
            if (k == 4 || k == 5) check("t4_flush_noreq", {31'b0, IF_mem_req_valid}, 32'd0);
            if (k == 6) check("t4_new_req_addr", IF_mem_req_addr, 32'h40);
            if (k >= 4 && k <= 8) check("t4_no_instr", {31'b0, IF_instr_valid}, 32'd0);
            if (k == 9) begin
                check("t4_instr_valid", {31'b0, IF_instr_valid}, 32'd1);
                check("t4_instr_pc", IF_instr_pc, 32'h40);
                check("t4_instr", IF_instr, word_at(32'h40));
            end
            next_cycle();
        end
        IF_redirect_valid = 1'b0;

        // 5: misaligned redirect is sticky; fetch wraps past 0xFFFF_FFFC
        mem_lat = 1;
        do_reset("t5_rst");
        for (int k = 0; k < 10; k++) begin
            IF_redirect_valid = (k == 0) || (k == 5);
            IF_redirect_pc    = (k == 0) ? 32'h0000_0202 : 32'hFFFF_FFFC;
            at_neg();
            if (k == 0) begin
                check("t5_mis_before", {31'b0, IF_misaligned}, 32'd0);
                check("t5_redir_noreq", {31'b0, IF_mem_req_valid}, 32'd0);
            end
            if (k == 1) begin
                check("t5_mis_set", {31'b0, IF_misaligned}, 32'd1);
                check("t5_req_valid", {31'b0, IF_mem_req_valid}, 32'd1);
                check("t5_req_addr", IF_mem_req_addr, 32'h200);
            end
            if (k == 3) check("t5_pc_aligned", IF_instr_pc, 32'h200);
            if (k == 6) begin
                check("t5_mis_sticky", {31'b0, IF_misaligned}, 32'd1);
                check("t5_top_addr", IF_mem_req_addr, 32'hFFFF_FFFC);
            end
            if (k == 7) check("t5_wrap_addr", IF_mem_req_addr, 32'h0);
            if (k == 8) check("t5_top_pc", IF_instr_pc, 32'hFFFF_FFFC);
            if (k == 9) begin
                check("t5_wrap_pc", IF_instr_pc, 32'h0);
                check("t5_wrap_instr", IF_instr, word_at(32'h0));
            end
            next_cycle();
        end
        IF_redirect_valid = 1'b0;

        // 6: reset while busy with reads in flight
        mem_lat        = 3;
        IF_instr_ready = 1'b0;
        do_reset("t6_rst");
        for (int k = 0; k < 4; k++) next_cycle();
        SYS_reset = 1'b1;
        at_neg();
        check("t6_busy_valid", {31'b0, IF_instr_valid}, 32'd1);
        check("t6_busy_pc", IF_instr_pc, 32'h0);
        next_cycle();
        at_neg();
        check_reset_outputs("t6_mid");
        next_cycle();
        SYS_reset = 1'b0;
        at_neg();
        check("t6_restart_valid", {31'b0, IF_mem_req_valid}, 32'd1);
        check("t6_restart_addr", IF_mem_req_addr, 32'h0);
        check("t6_restart_empty", {31'b0, IF_instr_valid}, 32'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
